load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-side counterpart to the datapath ALU's address/data output. Consumes the effective address and store data produced for RV32I loads/stores and executes the access on a word-wide data-memory bus.
- Generates byte strobes and lane-shifted write data for stores.
- Returns sign- or zero-extended read data for loads, with a misalignment error flag.
- Sits between execute stage and data memory; one access in flight at a time.

Parameters:
- ADDR_W, 32, width of request and memory address.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles waiting for mem_ready (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or timeout.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts/completes request this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (req_addr with bits[1:0] = 00).
- mem_wstrb  out  4  byte enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read word, valid in the cycle mem_ready=1 with mem_we=0.

Behaviour:
- Reset values: req_ready=0 during reset, then 1. rsp_valid, rsp_err, mem_valid, mem_we = 0. mem_wstrb = 0. rsp_rdata, mem_addr, mem_wdata = 0.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & req_ready; register we, funct3, addr, wdata.
  - If legal and aligned, go to MEM; otherwise go to RESP with err=1 and no memory access.
- Alignment rules:
  - Halfword (funct3[1:0]=01) requires addr[0]=0.
  - Word (010) requires addr[1:0]=00.
  - Byte is always aligned.
- Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
- MEM:
  - mem_valid=1. mem_addr, mem_we, mem_wstrb, mem_wdata are held stable until mem_ready.
  - On mem_ready, capture the read word, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in MEM and RESP.
- Latency:
  - Request accepted at edge 0; mem_valid high from cycle 1.
  - mem_ready seen at cycle k gives rsp_valid at cycle k+1.
  - Error path: rsp_valid at cycle 1.
- Store strobes:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
- Store data: byte replicated to all 4 lanes; halfword replicated to both halves; word passed unchanged.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8]; halfword = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word.
  - For loads, mem_wstrb = 0000 and mem_wdata = 0.
- mem_ready while mem_valid=0 is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until accepted.
- Reset mid-operation: next cycle mem_valid=0, no rsp_valid, FSM in IDLE, captured request discarded.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to MEM and increments each MEM cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES, mem_valid drops, the FSM goes to RESP, rsp_err=1 and rsp_rdata=0.
  - mem_ready in the same cycle as the limit wins: normal completion.
- LSU_TIMEOUT_EN undefined: no counter; MEM waits indefinitely.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80FF_1234 (mem_ready at cycle 1) -> mem_addr=0x1000, rsp_valid at cycle 2, rsp_rdata=0xFFFF_FF80, rsp_err=0. LBU at the same address -> 0x0000_0080.
- LH at 0x2002, mem_rdata=0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LW at 0x2000 -> 0x8001_7FFF.
- SB addr 0x3001, wdata=0xAABB_CCDD -> mem_wstrb=0010, mem_wdata=0xDDDD_DDDD, mem_we=1. SH at 0x3002 -> wstrb=1100, wdata=0xCCDD_CCDD.
- LW at 0x4002 -> no mem_valid ever; rsp_valid at cycle 1 with rsp_err=1, rsp_rdata=0. SH at 0x4001 gives the same result. Load with funct3=011 gives the same result.
- mem_ready held low 5 cycles then high -> mem_valid and mem_addr stable for 6 cycles, single rsp_valid, req_ready=0 throughout. rst asserted in MEM cycle 3 -> mem_valid=0 next cycle, no rsp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready tied low -> mem_valid drops after 4 MEM cycles, rsp_valid with rsp_err=1. Without the macro -> mem_valid stays high indefinitely.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: executes one RV32I load or store at a time on a word-wide
// data-memory bus. Stores get byte strobes and lane-replicated write data;
// loads return sign/zero-extended data. Misaligned or illegal requests
// complete with rsp_err set and never touch memory.
// Optional feature macro: LSU_TIMEOUT_EN adds a watchdog on mem_ready.
// It aborts the access after TIMEOUT_CYCLES memory cycles.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req_legal;
  logic              req_aligned;
  logic [3:0]        st_strb;
  logic [31:0]       st_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic              timeout;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog counts stalled MEM cycles; it is zero whenever we are outside
  // MEM, so it is always fresh on entry. A ready in the limit cycle wins.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == S_MEM && !mem_ready) begin
      cnt_d   = cnt_q + CNT_ONE;
      timeout = (cnt_d == CNT_LIM);
    end else if (state_q == S_MEM) begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Classify the incoming request: funct3 legality and natural alignment.
  always_comb begin
    if (req_we) req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (req_funct3[1:0])
      2'b01:   req_aligned = ~req_addr[0];
      2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
  end

  // Store lane steering from the captured request.
  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  // Load lane extraction and extension from the returned word.
  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Access sequencing: accept in IDLE, wait on memory in MEM, pulse in RESP.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = ~(req_legal & req_aligned);
          state_d = (req_legal & req_aligned) ? S_MEM : S_RESP;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state and held request fields, so the memory side
  // stays stable for the whole MEM wait and is all-zero elsewhere.
  always_comb begin
    req_ready = (state_q == S_IDLE) & ~rst;
    rsp_valid = (state_q == S_RESP);
    rsp_err   = (state_q == S_RESP) & err_q;
    rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
    mem_valid = (state_q == S_MEM);
    mem_we    = (state_q == S_MEM) & we_q;
    mem_addr  = (state_q == S_MEM) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_wstrb = (state_q == S_MEM && we_q) ? st_strb : 4'b0000;
    mem_wdata = (state_q == S_MEM && we_q) ? st_data : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors with known answers, stall and
// reset scenarios, the watchdog (both builds), then randomized traffic
// checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_pass = 0;
  int n_total = 0;

  // observations of the last transaction
  logic        o_ready_idle, o_ready_busy, o_unstable, o_mwe, o_err;
  logic [31:0] o_maddr, o_mwdata, o_rdata;
  logic [3:0]  o_mstrb;
  int          o_mem_cyc, o_lat, o_rsp_cnt;

  // reference model outputs
  logic        e_err;
  logic [31:0] e_maddr, e_wdata, e_rdata;
  logic [3:0]  e_strb;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] mw;
    logic [31:0] rd;
    logic [3:0]  strb;
    logic [31:0] mwd;
    logic        err;
  } vec_t;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: RV32I access rules expressed with plain arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] mw);
    int unsigned size, off;
    logic legal, aligned;
    logic [31:0] b, h;
    size = f3 % 4;
    off  = addr % 4;
    legal   = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    aligned = (size == 0) || (size == 1 && addr % 2 == 0) || (size == 2 && off == 0);
    e_err   = !(legal && aligned);
    e_maddr = addr - off;
    e_strb  = 4'b0000;
    e_wdata = 32'd0;
    e_rdata = 32'd0;
    if (!e_err && we) begin
      if (size == 0)      begin e_strb = 4'(1 << off); e_wdata = (wd & 32'hFF) * 32'h0101_0101; end
      else if (size == 1) begin e_strb = 4'(3 << off); e_wdata = (wd & 32'hFFFF) * 32'h0001_0001; end
      else                begin e_strb = 4'hF;         e_wdata = wd; end
    end
    if (!e_err && !we) begin
      b = (mw >> (8 * off)) & 32'hFF;
      h = (mw >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
        3'd0:    e_rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
        3'd1:    e_rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
        3'd4:    e_rdata = b;
        3'd5:    e_rdata = h;
        default: e_rdata = mw;
      endcase
    end
  endtask

  // Drive one request and record what the DUT did. Memory becomes ready in
  // the (stall+1)th cycle of mem_valid; mem_ready is noise while idle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mw, input int stall);
    int n;
    n = 0;
    o_ready_busy = 0; o_unstable = 0; o_lat = -1; o_rsp_cnt = 0;
    o_rdata = 'x; o_err = 'x; o_maddr = 'x; o_mstrb = 'x; o_mwdata = 'x; o_mwe = 'x;
    @(negedge clk);
    mem_ready = 1'b0;
    o_ready_idle = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int cyc = 1; cyc <= stall + 12; cyc++) begin
      if (req_ready && o_lat < 0) o_ready_busy = 1;
      if (mem_valid) begin
        n++;
        if (n == 1) begin
          o_maddr = mem_addr; o_mstrb = mem_wstrb; o_mwdata = mem_wdata; o_mwe = mem_we;
        end else if (mem_addr !== o_maddr || mem_wstrb !== o_mstrb ||
                     mem_wdata !== o_mwdata || mem_we !== o_mwe) begin
          o_unstable = 1;
        end
        mem_ready = (n > stall);
        mem_rdata = (n > stall) ? mw : $urandom;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (rsp_valid) begin
        o_rsp_cnt++;
        if (o_lat < 0) begin o_lat = cyc; o_rdata = rsp_rdata; o_err = rsp_err; end
      end
      if (o_lat > 0 && cyc == o_lat + 1) break;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    o_mem_cyc = n;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_total++;
    if ({rsp_valid, rsp_err, mem_valid, mem_we, mem_wstrb} !== 8'd0 ||
        rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
      $display("FAIL reset_outputs: got rv=%b re=%b mv=%b we=%b strb=%h rd=%h ma=%h wd=%h want all 0",
               rsp_valid, rsp_err, mem_valid, mem_we, mem_wstrb, rsp_rdata, mem_addr, mem_wdata);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_plan_vectors;
    vec_t v [12];
    int exp_lat, exp_mem;
    v[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 4'h0, 32'h0,         1'b0};
    v[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0,         32'h80FF_1234, 32'h0000_0080, 4'h0, 32'h0,         1'b0};
    v[2]  = '{1'b0, 3'b001, 32'h2002, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 4'h0, 32'h0,         1'b0};
    v[3]  = '{1'b0, 3'b101, 32'h2002, 32'h0,         32'h8001_7FFF, 32'h0000_8001, 4'h0, 32'h0,         1'b0};
    v[4]  = '{1'b0, 3'b010, 32'h2000, 32'h0,         32'h8001_7FFF, 32'h8001_7FFF, 4'h0, 32'h0,         1'b0};
    v[5]  = '{1'b1, 3'b000, 32'h3001, 32'hAABB_CCDD, 32'h1111_1111, 32'h0,         4'h2, 32'hDDDD_DDDD, 1'b0};
    v[6]  = '{1'b1, 3'b001, 32'h3002, 32'hAABB_CCDD, 32'h1111_1111, 32'h0,         4'hC, 32'hCCDD_CCDD, 1'b0};
    v[7]  = '{1'b1, 3'b010, 32'h5000, 32'h1234_5678, 32'h1111_1111, 32'h0,         4'hF, 32'h1234_5678, 1'b0};
    v[8]  = '{1'b0, 3'b010, 32'h4002, 32'h0,         32'h1111_1111, 32'h0,         4'h0, 32'h0,         1'b1};
    v[9]  = '{1'b1, 3'b001, 32'h4001, 32'h5555_AAAA, 32'h1111_1111, 32'h0,         4'h0, 32'h0,         1'b1};
    v[10] = '{1'b0, 3'b011, 32'h4000, 32'h0,         32'h1111_1111, 32'h0,         4'h0, 32'h0,         1'b1};
    v[11] = '{1'b1, 3'b100, 32'h5000, 32'h5555_AAAA, 32'h1111_1111, 32'h0,         4'h0, 32'h0,         1'b1};
    foreach (v[i]) begin
      run_txn(v[i].we, v[i].f3, v[i].addr, v[i].wd, v[i].mw, 0);
      exp_lat = v[i].err ? 1 : 2;
      exp_mem = v[i].err ? 0 : 1;
      n_total++; if (o_lat !== exp_lat) $display("FAIL vec%0d_latency: got %0d want %0d", i, o_lat, exp_lat); else n_pass++;
      n_total++; if (o_err !== v[i].err) $display("FAIL vec%0d_err: got %b want %b", i, o_err, v[i].err); else n_pass++;
      n_total++; if (o_rdata !== v[i].rd) $display("FAIL vec%0d_rdata: got %h want %h", i, o_rdata, v[i].rd); else n_pass++;
      n_total++; if (o_mem_cyc !== exp_mem) $display("FAIL vec%0d_mem_cycles: got %0d want %0d", i, o_mem_cyc, exp_mem); else n_pass++;
      if (!v[i].err) begin
        n_total++;
        if (o_maddr !== {v[i].addr[31:2], 2'b00} || o_mwe !== v[i].we ||
            o_mstrb !== v[i].strb || o_mwdata !== v[i].mwd)
          $display("FAIL vec%0d_mem_side: got addr=%h we=%b strb=%b wdata=%h want addr=%h we=%b strb=%b wdata=%h",
                   i, o_maddr, o_mwe, o_mstrb, o_mwdata, {v[i].addr[31:2], 2'b00}, v[i].we, v[i].strb, v[i].mwd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall;
    run_txn(1'b0, 3'b010, 32'h2000, 32'h0, 32'hCAFE_F00D, 5);
    n_total++; if (o_mem_cyc !== 6) $display("FAIL stall_mem_cycles: got %0d want 6", o_mem_cyc); else n_pass++;
    n_total++; if (o_unstable !== 1'b0) $display("FAIL stall_stability: got unstable=%b want 0", o_unstable); else n_pass++;
    n_total++; if (o_ready_busy !== 1'b0) $display("FAIL stall_req_ready: got busy-ready=%b want 0", o_ready_busy); else n_pass++;
    n_total++; if (o_rsp_cnt !== 1) $display("FAIL stall_rsp_count: got %0d want 1", o_rsp_cnt); else n_pass++;
    n_total++; if (o_lat !== 7) $display("FAIL stall_latency: got %0d want 7", o_lat); else n_pass++;
    n_total++; if (o_rdata !== 32'hCAFE_F00D) $display("FAIL stall_rdata: got %h want cafef00d", o_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (mem_valid !== 1'b1) $display("FAIL rstmid_in_mem: got mem_valid=%b want 1", mem_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (mem_valid !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL rstmid_after: got mem_valid=%b rsp_valid=%b want 0 0", mem_valid, rsp_valid);
    else n_pass++;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      if (rsp_valid || mem_valid) pulses++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    n_total++; if (pulses !== 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", pulses); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_timeout;
    // ready arriving in the 4th memory cycle completes normally in either build
    run_txn(1'b0, 3'b010, 32'h7000, 32'h0, 32'h0BAD_BEEF, 3);
    n_total++;
    if (o_err !== 1'b0 || o_rdata !== 32'h0BAD_BEEF || o_lat !== 5 || o_mem_cyc !== 4)
      $display("FAIL timeout_edge: got err=%b rdata=%h lat=%0d mem=%0d want 0 0badbeef 5 4",
               o_err, o_rdata, o_lat, o_mem_cyc);
    else n_pass++;
    run_txn(1'b0, 3'b010, 32'h7004, 32'h0, 32'h1357_9BDF, 20);
`ifdef LSU_TIMEOUT_EN
    n_total++;
    if (o_err !== 1'b1 || o_rdata !== 32'd0 || o_lat !== 5 || o_mem_cyc !== 4 || o_rsp_cnt !== 1)
      $display("FAIL timeout_fire: got err=%b rdata=%h lat=%0d mem=%0d rsp=%0d want 1 0 5 4 1",
               o_err, o_rdata, o_lat, o_mem_cyc, o_rsp_cnt);
    else n_pass++;
`else
    n_total++;
    if (o_err !== 1'b0 || o_rdata !== 32'h1357_9BDF || o_lat !== 22 || o_mem_cyc !== 21)
      $display("FAIL no_timeout: got err=%b rdata=%h lat=%0d mem=%0d want 0 13579bdf 22 21",
               o_err, o_rdata, o_lat, o_mem_cyc);
    else n_pass++;
`endif
  endtask

  task automatic test_random;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd, mw;
    int stall, exp_lat;
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom; mw = $urandom;
      stall = $urandom_range(0, 3);
      model(we, f3, addr, wd, mw);
      run_txn(we, f3, addr, wd, mw, stall);
      exp_lat = e_err ? 1 : stall + 2;
      n_total++; if (o_ready_idle !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", t, o_ready_idle); else n_pass++;
      n_total++; if (o_lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", t, o_lat, exp_lat); else n_pass++;
      n_total++;
      if (o_err !== e_err || o_rdata !== e_rdata || o_rsp_cnt !== 1)
        $display("FAIL rnd%0d_response: got err=%b rdata=%h n=%0d want err=%b rdata=%h n=1 (we=%b f3=%0d addr=%h)",
                 t, o_err, o_rdata, o_rsp_cnt, e_err, e_rdata, we, f3, addr);
      else n_pass++;
      if (e_err) begin
        n_total++; if (o_mem_cyc !== 0) $display("FAIL rnd%0d_no_access: got %0d mem cycles want 0", t, o_mem_cyc); else n_pass++;
      end else begin
        n_total++;
        if (o_mem_cyc !== stall + 1 || o_unstable !== 1'b0 || o_maddr !== e_maddr ||
            o_mwe !== we || o_mstrb !== e_strb || o_mwdata !== e_wdata)
          $display("FAIL rnd%0d_mem_side: got cyc=%0d unst=%b addr=%h we=%b strb=%b wd=%h want cyc=%0d unst=0 addr=%h we=%b strb=%b wd=%h",
                   t, o_mem_cyc, o_unstable, o_maddr, o_mwe, o_mstrb, o_mwdata,
                   stall + 1, e_maddr, we, e_strb, e_wdata);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_plan_vectors;
    test_stall;
    test_reset_mid;
    test_timeout;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
